// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the address/instruction width defaults, the reset PC, the PC increment and the queue entry layout.
// No logic lives here.
package instruction_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned INST_W_DEF = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  // Every fetch advances the PC by one 32-bit instruction.
  localparam int unsigned PC_INC = 4;

  // The fetch queue stores {pc, inst} in exactly this packed order.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Purpose: synchronous FIFO of fetch entries; the head is read combinationally from the registered read pointer.
// Latency: a push in cycle N is visible at o_head/o_count in cycle N+1.
// Backpressure: a push is dropped when full unless a pop happens in the same cycle; a pop on empty is ignored.
module fetch_queue #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [W-1:0]           i_wdat,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against underflow and overflow locally so the queue is safe on its own.
  always_comb begin
    w_pop  = i_pop & (r_count != '0);
    w_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);
  end

  // Storage, pointers and count. Reset wipes the entries so the head reads as zero; clear only empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdat;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose: owns the PC, reads instruction memory combinationally and queues {pc, inst} pairs for decode.
// Latency: the first instruction after reset or redirect is presented one cycle later; one per cycle in steady state.
// Backpressure: with out_ready low the queue fills and the PC freezes; memory is re-read on resume, so nothing is lost.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      Inst_Address,
  input  logic [INST_W-1:0]      Instruction,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_W-1:0]      out_inst,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ENT_W-1:0]  w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_out_valid;
  logic              w_pop;
  logic              w_push;

  // Handshake: the head is only dequeued when present; the PC only advances when there is room for its entry.
  always_comb begin
    w_out_valid = (w_count != '0);
    w_pop       = w_out_valid & out_ready;
    w_push      = ~redirect_valid & ((w_count != CNT_W'(DEPTH)) | w_pop);
  end

  // PC register: reset beats redirect, redirect suppresses the fetch, otherwise advance on each enqueue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(PC_INC);
    end
  end

  fetch_queue #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .i_wdat  ({r_pc, Instruction}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign Inst_Address = r_pc;
  assign out_valid    = w_out_valid;
  assign out_pc       = w_head[ENT_W-1:INST_W];
  assign out_inst     = w_head[INST_W-1:0];
  assign occupancy    = w_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a reference model predicts PC, queue contents and occupancy.
// Expected entries are queued when a fetch is predicted and compared when decode takes the head.
// Directed phases follow the fetch scenarios, followed by a random out_ready phase.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [63:0]  m_pc;
  int           m_cnt;
  fetch_entry_t exp_q[$];
  logic [63:0]  m_last_acc;
  bit           m_have_last;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h0F053483;
      64'd4:   return 32'h009A84B3;
      64'd8:   return 32'h00148493;
      64'd12:  return 32'h0E953823;
      default: return 32'h0;
    endcase
  endfunction

  assign Instruction = mem_rd(Inst_Address);

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .Inst_Address   (Inst_Address),
    .Instruction    (Instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .occupancy      (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = 64'h0;
    m_cnt       = 0;
    m_have_last = 1'b0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, compare DUT against the model, advance the model, cross the edge.
  task automatic cycle(input bit rdy, input bit redir, input logic [63:0] rpc, input bit rst);
    bit           pop;
    bit           push;
    fetch_entry_t e;
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    chk("inst_addr", Inst_Address, m_pc);
    chk("occupancy", 64'(occupancy), 64'(m_cnt));
    chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
    chk("occ_range", 64'(occupancy <= 3'd4), 64'd1);
    if (m_cnt != 0) begin
      chk("head_pc", out_pc, exp_q[0].pc);
      chk("head_inst", 64'(out_inst), 64'(exp_q[0].inst));
    end
    if (rst) begin
      model_reset();
    end else if (redir) begin
      m_pc        = {rpc[63:2], 2'b00};
      m_cnt       = 0;
      m_have_last = 1'b0;
      exp_q.delete();
    end else begin
      pop  = (m_cnt != 0) && rdy;
      push = (m_cnt < 4) || pop;
      if (pop) begin
        if (m_have_last) chk("acc_seq", out_pc, m_last_acc + 64'd4);
        m_last_acc  = exp_q[0].pc;
        m_have_last = 1'b1;
        void'(exp_q.pop_front());
        m_cnt--;
      end
      if (push) begin
        e.pc   = m_pc;
        e.inst = mem_rd(m_pc);
        exp_q.push_back(e);
        m_pc = m_pc + 64'd4;
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_addr", Inst_Address, 64'd0);

    // Streaming with out_ready held high.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0);

    // Back-pressure from reset, then one ready pulse.
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("full_addr", Inst_Address, 64'd16);
    chk("full_occ", 64'(occupancy), 64'd4);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("pulse_head", out_pc, 64'd4);
    chk("pulse_occ", 64'(occupancy), 64'd4);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // Redirect to 0x9 with three entries queued.
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("pre_redir_occ", 64'(occupancy), 64'd3);
    cycle(1'b1, 1'b1, 64'h9, 1'b0);
    chk("redir_addr", Inst_Address, 64'd8);
    chk("redir_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    chk("redir_head_pc", out_pc, 64'd8);
    chk("redir_head_inst", 64'(out_inst), 64'h00148493);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);

    // Redirect and reset together: reset wins.
    cycle(1'b1, 1'b1, 64'h40, 1'b1);
    chk("rst_redir_addr", Inst_Address, 64'd0);
    chk("rst_redir_occ", 64'(occupancy), 64'd0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, 1'b0);

    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      chk("wrap_addr_known", 64'($isunknown(Inst_Address)), 64'd0);
    end

    // Random back-pressure from a fresh start.
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 1000; i++) cycle(bit'($urandom_range(0, 1)), 1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
